// File: rtl/lm32_ram_write_arbiter_if.sv
// Write-side bus of the RAM write arbiter: flush request, two write requesters,
// their grants and the RAM write port with sweep status.
interface lm32_ram_write_arbiter_if #(
    parameter int addr_width = 10,
    parameter int data_width = 8
);
    logic                  flush_i;
    logic                  a_req_i;
    logic [addr_width-1:0] a_addr_i;
    logic [data_width-1:0] a_data_i;
    logic                  b_req_i;
    logic [addr_width-1:0] b_addr_i;
    logic [data_width-1:0] b_data_i;
    logic                  a_gnt_o;
    logic                  b_gnt_o;
    logic                  ram_we_o;
    logic [addr_width-1:0] ram_waddr_o;
    logic [data_width-1:0] ram_wdata_o;
    logic                  busy_o;
    logic                  done_o;

    modport slave (
        input  flush_i, a_req_i, a_addr_i, a_data_i, b_req_i, b_addr_i, b_data_i,
        output a_gnt_o, b_gnt_o, ram_we_o, ram_waddr_o, ram_wdata_o, busy_o, done_o
    );

    modport master (
        output flush_i, a_req_i, a_addr_i, a_data_i, b_req_i, b_addr_i, b_data_i,
        input  a_gnt_o, b_gnt_o, ram_we_o, ram_waddr_o, ram_wdata_o, busy_o, done_o
    );
endinterface

// File: rtl/lm32_ram_write_arbiter.sv
// Owns the RAM write port: sweeps init_value over the whole RAM after reset or
// flush, otherwise grants one of two writers per cycle in round-robin order.
module lm32_ram_write_arbiter #(
    parameter int                        addr_width = 10,
    parameter int                        addr_depth = 1024,
    parameter int                        data_width = 8,
    parameter logic [data_width-1:0]     init_value = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    lm32_ram_write_arbiter_if.slave  bus
);
    typedef enum logic {SWEEP, ARB} state_t;

    localparam logic [addr_width-1:0] last_addr = addr_width'(addr_depth - 1);

    state_t                state_reg, state_next;
    logic [addr_width-1:0] cnt_reg, cnt_next;
    logic                  last_b_reg, last_b_next;
    logic                  done_reg, done_next;

    logic                  a_gnt, b_gnt, we, busy;
    logic [addr_width-1:0] waddr;
    logic [data_width-1:0] wdata;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg  <= SWEEP;
            cnt_reg    <= '0;
            last_b_reg <= 1'b1;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            last_b_reg <= last_b_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        last_b_next = last_b_reg;
        done_next   = 1'b0;
        a_gnt       = 1'b0;
        b_gnt       = 1'b0;
        we          = 1'b0;
        waddr       = '0;
        wdata       = '0;
        busy        = 1'b0;

        case (state_reg)
            SWEEP: begin
                we    = 1'b1;
                waddr = cnt_reg;
                wdata = init_value;
                busy  = 1'b1;
                if (cnt_reg == last_addr) begin
                    state_next = ARB;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                if (bus.flush_i) begin
                    state_next = SWEEP;
                    cnt_next   = '0;
                end else if (bus.a_req_i && (!bus.b_req_i || last_b_reg)) begin
                    a_gnt       = 1'b1;
                    we          = 1'b1;
                    waddr       = bus.a_addr_i;
                    wdata       = bus.a_data_i;
                    last_b_next = 1'b0;
                end else if (bus.b_req_i) begin
                    b_gnt       = 1'b1;
                    we          = 1'b1;
                    waddr       = bus.b_addr_i;
                    wdata       = bus.b_data_i;
                    last_b_next = 1'b1;
                end
            end
        endcase

        // While reset is held, readers see busy and nothing reaches the RAM.
        if (!rst_i) begin
            a_gnt = 1'b0;
            b_gnt = 1'b0;
            we    = 1'b0;
            waddr = '0;
            wdata = '0;
            busy  = 1'b1;
        end
    end

    assign bus.a_gnt_o     = a_gnt;
    assign bus.b_gnt_o     = b_gnt;
    assign bus.ram_we_o    = we;
    assign bus.ram_waddr_o = waddr;
    assign bus.ram_wdata_o = wdata;
    assign bus.busy_o      = busy;
    assign bus.done_o      = done_reg;
endmodule

// File: tb/tb_lm32_ram_write_arbiter.sv
// Scoreboard bench: stimulus queues expected RAM-port events, a negedge monitor
// pops one per write or done pulse and compares the whole output vector.
module tb_lm32_ram_write_arbiter;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam logic [DW-1:0] INIT = 8'hA5;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          ag;
        logic          bg;
        logic          busy;
        logic          done;
    } ev_t;

    logic clk_i = 1'b0;
    logic rst_i;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_ev = 0;
    ev_t  exp_q[$];

    lm32_ram_write_arbiter_if #(.addr_width(AW), .data_width(DW)) bus ();

    lm32_ram_write_arbiter #(
        .addr_width(AW), .addr_depth(DEPTH), .data_width(DW), .init_value(INIT)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus(bus)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: every write or done pulse must match the next queued event.
    always @(negedge clk_i) begin
        if (bus.ram_we_o || bus.done_o) begin
            ev_t got, exp;
            got = '{bus.ram_we_o, bus.ram_waddr_o, bus.ram_wdata_o,
                    bus.a_gnt_o, bus.b_gnt_o, bus.busy_o, bus.done_o};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL event[%0d] unexpected: got we=%0b addr=%0h data=%0h ag=%0b bg=%0b busy=%0b done=%0b, expected none",
                         n_ev, got.we, got.addr, got.data, got.ag, got.bg, got.busy, got.done);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL event[%0d]: got we=%0b addr=%0h data=%0h ag=%0b bg=%0b busy=%0b done=%0b, expected we=%0b addr=%0h data=%0h ag=%0b bg=%0b busy=%0b done=%0b",
                             n_ev, got.we, got.addr, got.data, got.ag, got.bg, got.busy, got.done,
                             exp.we, exp.addr, exp.data, exp.ag, exp.bg, exp.busy, exp.done);
                end else begin
                    $display("event[%0d] we=%0b addr=%0h data=%0h ag=%0b bg=%0b busy=%0b done=%0b",
                             n_ev, got.we, got.addr, got.data, got.ag, got.bg, got.busy, got.done);
                end
            end
            n_ev++;
        end
    end

    task automatic push(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic ag, input logic bg, input logic busy, input logic done);
        ev_t e;
        e = '{we, addr, data, ag, bg, busy, done};
        exp_q.push_back(e);
    endtask

    task automatic push_sweep(input int n);
        for (int i = 0; i < n; i++) push(1'b1, AW'(i), INIT, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end else begin
            $display("check %s = %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic ar, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic br, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        bus.a_req_i  = ar;
        bus.a_addr_i = aa;
        bus.a_data_i = ad;
        bus.b_req_i  = br;
        bus.b_addr_i = ba;
        bus.b_data_i = bd;
    endtask

    task automatic wait_done(input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (bus.done_o) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s: done_o not seen within 40 cycles", name);
        end
    endtask

    initial begin
        rst_i = 1'b0;
        bus.flush_i = 1'b0;
        drive(1'b1, 5'd1, 8'h01, 1'b1, 5'd2, 8'h02);
        tick();
        tick();
        #1;
        check("reset_busy", {31'd0, bus.busy_o}, 32'd1);
        check("reset_we", {31'd0, bus.ram_we_o}, 32'd0);
        check("reset_gnt", {30'd0, bus.a_gnt_o, bus.b_gnt_o}, 32'd0);
        check("reset_done", {31'd0, bus.done_o}, 32'd0);

        // First sweep starts on its own after release.
        push_sweep(DEPTH);
        push(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        rst_i = 1'b1;
        wait_done("sweep1_done");
        tick();
        check("arb_busy", {31'd0, bus.busy_o}, 32'd0);

        // Both held six cycles: A first (last_b=1 after reset), then alternation.
        for (int i = 0; i < 3; i++) begin
            push(1'b1, 5'd3, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
            push(1'b1, 5'd7, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        push(1'b1, 5'd20, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
        push(1'b1, 5'd1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b1, 5'd2, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0);
        push(1'b1, 5'd4, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b1, 5'd6, 8'h99, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 5'd3, 8'h11, 1'b1, 5'd7, 8'h22);
        repeat (6) tick();
        drive(1'b0, 5'd3, 8'h11, 1'b1, 5'd20, 8'h33);
        tick();
        drive(1'b1, 5'd1, 8'h55, 1'b1, 5'd2, 8'h66);
        tick();
        tick();
        drive(1'b1, 5'd4, 8'h77, 1'b0, 5'd2, 8'h66);
        tick();
        drive(1'b0, 5'd12, 8'hEE, 1'b0, 5'd13, 8'hDD);
        #1;
        check("idle_we", {31'd0, bus.ram_we_o}, 32'd0);
        check("idle_addr", {27'd0, bus.ram_waddr_o}, 32'd0);
        check("idle_data", {24'd0, bus.ram_wdata_o}, 32'd0);
        check("idle_gnt", {30'd0, bus.a_gnt_o, bus.b_gnt_o}, 32'd0);
        tick();
        drive(1'b1, 5'd5, 8'h88, 1'b1, 5'd6, 8'h99);
        tick();

        // Flush beats a pending A request; A is served right after the sweep.
        push_sweep(DEPTH);
        push(1'b1, 5'd9, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 5'd9, 8'h44, 1'b0, '0, '0);
        bus.flush_i = 1'b1;
        #1;
        check("flush_a_gnt", {31'd0, bus.a_gnt_o}, 32'd0);
        check("flush_we", {31'd0, bus.ram_we_o}, 32'd0);
        tick();
        bus.flush_i = 1'b0;
        wait_done("sweep2_done");
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0);

        // Flush during a sweep (cnt=5) is ignored.
        push_sweep(DEPTH);
        push(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        repeat (5) tick();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        wait_done("sweep3_done");
        tick();

        // Reset at cnt=9 abandons the sweep; a full one follows release.
        push_sweep(9);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        repeat (9) tick();
        rst_i = 1'b0;
        bus.b_req_i = 1'b1;
        #1;
        check("midreset_busy", {31'd0, bus.busy_o}, 32'd1);
        check("midreset_we", {31'd0, bus.ram_we_o}, 32'd0);
        check("midreset_b_gnt", {31'd0, bus.b_gnt_o}, 32'd0);
        tick();
        push_sweep(DEPTH);
        push(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.b_req_i = 1'b0;
        rst_i = 1'b1;
        wait_done("sweep4_done");
        tick();
        check("final_busy", {31'd0, bus.busy_o}, 32'd0);
        repeat (3) tick();
        check("queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lm32_ram_write_arbiter.md
LM32_RAM_WRITE_ARBITER -- requirements
Module: lm32_ram_write_arbiter

Interface
REQ-001 The block SHALL have parameter addr_width, default 10, meaning the width of every address port.
REQ-002 The block SHALL have parameter addr_depth, default 1024, meaning the number of RAM entries swept; the legal range is 1 to 2**addr_width.
REQ-003 The block SHALL have parameter data_width, default 8, meaning the width of every data port.
REQ-004 The block SHALL have parameter init_value, default all-zero (data_width bits), meaning the word written by every sweep.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port flush_i, input, 1 bit: a one-cycle request to start a full sweep.
REQ-008 The block SHALL have ports a_req_i (1), a_addr_i (addr_width) and a_data_i (data_width), all inputs: requester A write request.
REQ-009 The block SHALL have ports b_req_i (1), b_addr_i (addr_width) and b_data_i (data_width), all inputs: requester B write request.
REQ-010 The block SHALL have outputs a_gnt_o (1) and b_gnt_o (1): the write of that requester is performed this cycle.
REQ-011 The block SHALL have outputs ram_we_o (1), ram_waddr_o (addr_width) and ram_wdata_o (data_width), driving the write port of the dual-port RAM.
REQ-012 The block SHALL have output busy_o, 1 bit: a sweep is in progress and the readers must discard read data.
REQ-013 The block SHALL have output done_o, 1 bit: a one-cycle pulse at the end of a sweep.

Function
REQ-014 The block SHALL have exactly two states, SWEEP and ARB.
REQ-015 The block SHALL hold a sweep counter cnt of addr_width bits and a last-grant flag last_b.
REQ-016 In SWEEP, the outputs SHALL be ram_we_o=1, ram_waddr_o=cnt, ram_wdata_o=init_value, busy_o=1, a_gnt_o=0 and b_gnt_o=0.
REQ-017 In SWEEP, cnt SHALL increment by 1 every cycle.
REQ-018 In SWEEP, when cnt==addr_depth-1, the next state SHALL be ARB, cnt SHALL clear to 0 and done_o SHALL be 1 in the following cycle only.
REQ-019 A sweep SHALL therefore take exactly addr_depth cycles, and addresses at or above addr_depth SHALL never be written by a sweep.
REQ-020 flush_i SHALL be ignored in SWEEP; a sweep is neither restarted nor extended by it.
REQ-021 In ARB with flush_i=1, the next state SHALL be SWEEP with cnt=0, the grants SHALL be 0 and ram_we_o SHALL be 0 that cycle; flush takes priority over all requests.
REQ-022 In ARB with flush_i=0, the grant SHALL be combinational in the same cycle, with no added latency.
REQ-023 In ARB with only A requesting, a_gnt_o SHALL be 1; with only B requesting, b_gnt_o SHALL be 1.
REQ-024 In ARB with both requesting, the grant SHALL go to A if last_b=1 and to B if last_b=0 (round robin).
REQ-025 On any grant, ram_we_o SHALL be 1 and ram_waddr_o and ram_wdata_o SHALL equal the winner's addr and data.
REQ-026 On any grant, last_b SHALL update at the clock edge to 1 if B won and to 0 if A won.
REQ-027 In ARB with no request and no flush, ram_we_o SHALL be 0, ram_waddr_o SHALL be 0, ram_wdata_o SHALL be 0 and last_b SHALL be unchanged.
REQ-028 At most one of a_gnt_o and b_gnt_o SHALL be 1 in any cycle, and neither SHALL be 1 unless its req is 1.
REQ-029 A requester SHALL hold req, addr and data stable until it sees gnt; it may present a new request in the cycle after gnt, giving one write per cycle sustained.
REQ-030 busy_o SHALL be 0 in ARB.

Reset
REQ-031 With rst_i=0 at a clock edge, the state SHALL become SWEEP, with cnt=0, last_b=1 and done_o=0.
REQ-032 After rst_i returns to 1, the first sweep SHALL start automatically, so that reset always initialises the RAM.
REQ-033 During the cycles with rst_i=0, busy_o SHALL be 1, ram_we_o SHALL be 0 and the grants SHALL be 0.
REQ-034 Reset asserted mid-sweep or mid-arbitration SHALL abandon the current operation, and a full sweep SHALL follow reset release.

Verification
REQ-035 With addr_depth=16 and init_value=8'hA5, release reset: the bench SHALL see 16 writes of A5 to addresses 0..15 on consecutive cycles with busy_o=1, then done_o=1 for one cycle, then busy_o=0.
REQ-036 After the sweep, drive a_req=1 (addr 3, data 11) and b_req=1 (addr 7, data 22) together: the bench SHALL see A granted first, writing 11 to address 3; then B, writing 22 to address 7; with no idle cycle between.
REQ-037 With both requests held high for 6 cycles, the bench SHALL see the grants alternate A,B,A,B,A,B.
REQ-038 Pulse flush_i in the same cycle as a_req=1: the bench SHALL see a_gnt_o=0 and ram_we_o=0, then a 16-cycle sweep; after done_o, A SHALL be granted.
REQ-039 Pulse flush_i while cnt=5 in a sweep: the bench SHALL see the sweep end at cnt=15 with a single done_o pulse.
REQ-040 Assert rst_i=0 while cnt=9, then release: the bench SHALL see the sweep restart at address 0 and run a full 16 cycles.
